seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Parametrised multiplexed 7-segment display driver. Successor to the fixed 6-digit distance display.
- Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially (double-dabble, one bit per cycle).
- Scans N_DIGITS common-select digits at a configurable dwell time.
- Adds leading-zero blanking, a runtime decimal-point position, an overflow indication (all dashes) and configurable seg/sel polarity. Sits between measurement logic (e.g. ultrasonic range) and the board display pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SCAN_HZ, 1000, per-digit refresh rate. DWELL = CLK_HZ/SCAN_HZ cycles per digit; DWELL must be >= 2.
- N_DIGITS, 8, number of digits driven, legal range 2..8.
- DATA_W, 20, width of the binary input, legal range 4..27.
- SEG_ACT_LOW, 1, 1 = segment lines active-low.
- SEL_ACT_LOW, 0, 1 = select lines active-low.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- data_in  in  DATA_W  unsigned binary value to display
- data_vld  in  1  data_in valid
- data_rdy  out  1  block can accept a value
- dp_en  in  1  enable the decimal point
- dp_pos  in  3  digit index carrying the dp (0 = rightmost digit)
- blank_lz  in  1  enable leading-zero blanking
- sel  out  N_DIGITS  one-hot digit select
- seg  out  8  segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (rstn asynchronous, active-low; clock clk), applied at any time including mid-conversion:
  - Conversion aborted; state IDLE.
  - data_rdy=1.
  - Display register = value 0, overflow flag cleared.
  - Scan index 0, dwell counter 0.
  - sel = bit0 active, other bits inactive (polarity per SEL_ACT_LOW).
  - seg = all segments off.
- Handshake: transfer occurs on the edge where data_vld && data_rdy. data_rdy=1 only in IDLE. data_vld while busy is ignored; there is no queue.
- FSM:
  - IDLE: on transfer, capture data_in into the shift register, clear BCD (4*N_DIGITS bits), set ovf = (data_in > 10^N_DIGITS-1), go to SHIFT with bit counter 0.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left 1. Exactly DATA_W cycles, then go to LOAD.
  - LOAD: copy BCD and ovf into the display register atomically, go to IDLE.
- Latency: display register updated on edge DATA_W+1 after the transfer edge. data_rdy returns high on that same edge.
- The display never shows a partially converted value.
- Scan:
  - Dwell counter runs 0..DWELL-1 continuously, independent of conversion.
  - At the wrap, the index increments; N_DIGITS-1 wraps to 0.
  - sel and seg are both registered and update on the same edge (one cycle after the index changes), so they are always coherent.
- Digit content for index i, evaluated in order:
  - ovf=1: dash (segment g only), dp off, on all digits.
  - Blanking: blank_lz=1, i > dp_pos (if dp_en=1) or i > 0 (if dp_en=0), and BCD digits i..N_DIGITS-1 are all zero -> all segments off. Digit 0 is never blanked.
  - Otherwise: the BCD digit glyph. Nibbles > 9 are impossible; decode them as blank.
  - dp segment lit iff dp_en && i == dp_pos && !ovf. dp_pos >= N_DIGITS means no dp.
- Glyphs, active-high {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40.
  - SEG_ACT_LOW inverts all 8 bits. Example: active-low 0 = C0.
- dp_en, dp_pos and blank_lz are used live each cycle and are not latched.

Test Plan:
- Reset with defaults (N_DIGITS=8, SEL_ACT_LOW=0, SEG_ACT_LOW=1) -> sel=8'h01, seg=8'hFF, data_rdy=1; first scan step after DWELL+1 cycles -> sel=8'h02.
- data_in=12345, dp_en=1, dp_pos=3, blank_lz=0 -> data_rdy low exactly 21 cycles. Digits 0..7 = 5,4,3,2,1,0,0,0; digit3 seg=8'h24; digit7 seg=8'hC0.
- data_in=7, dp_en=0, blank_lz=1 -> digit0 seg=8'hF8, digits 1..7 seg=8'hFF. Then dp_en=1, dp_pos=2 -> digits 1,2 show C0, with digit2 = 8'h40.
- N_DIGITS=4: data_in=10000 -> all digits 8'hBF, no dp. data_in=9999 -> all digits 8'h90.
- Pulse data_vld with 100, then with 200 two cycles later (busy) -> display shows 100; 200 is dropped. Re-present 200 when data_rdy=1 -> display shows 200.
- Assert rstn low mid-SHIFT of 54321 -> display value 0, data_rdy=1 and sel=bit0 immediately (asynchronous); a new value converts normally after release.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment driver with sequential binary-to-BCD conversion
// Converts one value at a time (double-dabble) and scans N_DIGITS digits at a fixed dwell.
module seg_scan_driver #(
  parameter int CLK_HZ      = 50000000,
  parameter int SCAN_HZ     = 1000,
  parameter int N_DIGITS    = 8,
  parameter int DATA_W      = 20,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_vld,
  output logic                data_rdy,
  input  logic                dp_en,
  input  logic [2:0]          dp_pos,
  input  logic                blank_lz,
  output logic [N_DIGITS-1:0] sel,
  output logic [7:0]          seg
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CW    = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int IW    = $clog2(N_DIGITS);
  localparam int BW    = 4 * N_DIGITS;
  localparam int KW    = $clog2(DATA_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;
  localparam logic [7:0] SEG_INV = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] SEL_INV = SEL_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [N_DIGITS-1:0] SEL_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t            state;
  logic [DATA_W-1:0] bin_sh;
  logic [BW-1:0]     bcd;
  logic              ovf_cv;
  logic [KW-1:0]     bit_cnt;
  logic [BW-1:0]     disp_bcd;
  logic              disp_ovf;

  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_nxt;
  logic [DATA_W-1:0] bin_nxt;
  logic              in_ovf;

  assign in_ovf = {{(64-DATA_W){1'b0}}, data_in} > MAX_VAL;

  // Double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left by one.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[BW-2:0], bin_sh[DATA_W-1]};
    bin_nxt = {bin_sh[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      data_rdy <= 1'b1;
      bin_sh   <= '0;
      bcd      <= '0;
      ovf_cv   <= 1'b0;
      bit_cnt  <= '0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_vld) begin
            bin_sh   <= data_in;
            bcd      <= '0;
            ovf_cv   <= in_ovf;
            bit_cnt  <= '0;
            data_rdy <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd     <= bcd_nxt;
          bin_sh  <= bin_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == KW'(DATA_W - 1)) state <= LOAD;
        end
        LOAD: begin
          disp_bcd <= bcd;
          disp_ovf <= ovf_cv;
          data_rdy <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          data_rdy <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  logic [CW-1:0] dwell_cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dwell_cnt <= '0;
      idx       <= '0;
    end else if (dwell_cnt == CW'(DWELL - 1)) begin
      dwell_cnt <= '0;
      idx       <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  logic [N_DIGITS-1:0] zero_from;
  logic                run_zero;
  logic [3:0]          cur_nib;
  logic                cur_zero;
  logic [2:0]          idx3;
  logic [2:0]          lz_lim;
  logic                blank;
  logic                dp_on;
  logic [6:0]          glyph;
  logic [7:0]          seg_raw;

  // zero_from[i] is set when digits i..N_DIGITS-1 of the display are all zero.
  always_comb begin
    zero_from = '0;
    run_zero  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero && (disp_bcd[4*i +: 4] == 4'd0);
      zero_from[i] = run_zero;
    end
  end

  always_comb begin
    cur_nib  = 4'd0;
    cur_zero = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib  = disp_bcd[4*i +: 4];
        cur_zero = zero_from[i];
      end
    end
  end

  always_comb begin
    case (cur_nib)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  end

  assign idx3    = 3'(idx);
  assign lz_lim  = dp_en ? dp_pos : 3'd0;
  assign blank   = blank_lz && (idx3 > lz_lim) && cur_zero;
  assign dp_on   = dp_en && (idx3 == dp_pos) && !disp_ovf;
  assign seg_raw = disp_ovf ? 8'h40 : {dp_on, (blank ? 7'h00 : glyph)};

  // sel and seg come from the same idx on the same edge so they never disagree.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel <= SEL_ONE ^ SEL_INV;
      seg <= SEG_INV;
    end else begin
      sel <= (SEL_ONE << idx) ^ SEL_INV;
      seg <= seg_raw ^ SEG_INV;
    end
  end

endmodule
